// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer
//   Captures every result pulse from the FPU top into a small FIFO. The FPU
//   ignores back-pressure, so credits are issued upstream to guarantee a free
//   slot for every op in flight. Results go to writeback with a valid/ready
//   handshake. The block also accumulates retired exception flags for fflags.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous flush: drops all entries and credits
//   issue_i              one op accepted by the FPU this cycle
//   can_issue_o          room for one more op (occupancy + inflight < DEPTH)
//   fpu_valid_i          result pulse from the FPU
//   fpu_result_i/status_i/tag_i   result payload
//   out_valid_o/out_ready_i       writeback handshake
//   out_result_o/status_o/tag_o   head entry, reads 0 when empty
//   fflags_o, fflags_clr_i        sticky OR of retired status, CSR clear
//   overflow_o           sticky: a result arrived while full and was dropped
//   occupancy_o          entries held
//   inflight_o           ops issued and not yet returned
module fpu_result_buffer #(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 issue_i,
    output logic                 can_issue_o,
    input  logic                 fpu_valid_i,
    input  logic [WIDTH-1:0]     fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic [TAG_WIDTH-1:0] fpu_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_result_o,
    output logic [4:0]           out_status_o,
    output logic [TAG_WIDTH-1:0] out_tag_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic                 overflow_o,
    output logic [CNT_W-1:0]     occupancy_o,
    output logic [CNT_W-1:0]     inflight_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_result [DEPTH];
    logic [4:0]           mem_status [DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] inflight;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [CNT_W:0]   committed;

    assign full        = (occupancy == CNT_W'(DEPTH));
    assign out_valid_o = (occupancy != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign push        = fpu_valid_i && (!full || pop);
    assign drop        = fpu_valid_i && full && !pop;

    // Head read is combinational; gated so an empty buffer presents zeros
    // regardless of stale storage contents.
    assign out_result_o = out_valid_o ? mem_result[rd_ptr] : '0;
    assign out_status_o = out_valid_o ? mem_status[rd_ptr] : '0;
    assign out_tag_o    = out_valid_o ? mem_tag[rd_ptr]    : '0;

    // Credit check uses only registered counters, one bit wider to avoid wrap.
    assign committed   = {1'b0, occupancy} + {1'b0, inflight};
    assign can_issue_o = (committed < (CNT_W + 1)'(DEPTH));

    assign occupancy_o = occupancy;
    assign inflight_o  = inflight;

    // Storage has no reset: contents are only observed through the gated read.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_result[wr_ptr] <= fpu_result_i;
            mem_status[wr_ptr] <= fpu_status_i;
            mem_tag[wr_ptr]    <= fpu_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            inflight   <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            inflight   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - CNT_W'(1);
            end
            // Saturating credit counter; a stray return at zero is tolerated.
            if (issue_i && !fpu_valid_i) begin
                if (inflight != CNT_W'(DEPTH)) begin
                    inflight <= inflight + CNT_W'(1);
                end
            end else if (fpu_valid_i && !issue_i) begin
                if (inflight != '0) begin
                    inflight <= inflight - CNT_W'(1);
                end
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // fflags is architectural CSR state, so flush does not touch it; a pop in
    // a flush cycle still retires its status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_o <= '0;
        end else if (fflags_clr_i) begin
            fflags_o <= pop ? out_status_o : 5'b00000;
        end else if (pop) begin
            fflags_o <= fflags_o | out_status_o;
        end
    end

endmodule
